// File: rtl/imem_pkg.sv
// Shared packet-network constants and FSM encoding for the input-memory row server.
package imem_pkg;

    localparam int ADDR_W   = 4;
    localparam int OPCODE_W = 4;
    localparam int DATA_W   = 25;

    localparam logic [OPCODE_W-1:0] OP_WEIGHT        = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_INPUT         = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_TIMESTEP_DONE = 4'd15;
    localparam logic [ADDR_W-1:0]   IMEM_ID          = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_SERVE,
        ST_BCAST
    } state_e;

    // Index width that stays legal for single-entry dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imem_row_store.sv
// Input spike-map storage: one row per address, synchronous write, registered read.
module imem_row_store
    import imem_pkg::*;
#(
    parameter int NUM_TS = 2,
    parameter int ROWS   = 25,
    parameter int WIDTH  = 25
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [idx_w(NUM_TS)-1:0]   wr_ts,
    input  logic [idx_w(ROWS)-1:0]     wr_row,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic [idx_w(NUM_TS)-1:0]   rd_ts,
    input  logic [idx_w(ROWS)-1:0]     rd_row,
    output logic [WIDTH-1:0]           rd_data
);

    logic [WIDTH-1:0] mem [NUM_TS][ROWS];

    // NOTE: the array has no reset so it maps onto plain storage; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ts][wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_ts][rd_row];
        end
    end

endmodule

// File: rtl/imem_row_server.sv
// Primes each PPE with its first input row, serves follow-up row requests, and
// broadcasts timestep-done markers between timesteps.
module imem_row_server
    import imem_pkg::*;
#(
    parameter int IFMAP_SIZE    = 25,
    parameter int NUM_PPE       = 5,
    parameter int ROWS_PER_PPE  = 5,
    parameter int NUM_TS        = 2,
    parameter int PPE_BASE_ADDR = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [idx_w(NUM_TS)-1:0]       wr_ts,
    input  logic [idx_w(IFMAP_SIZE)-1:0]   wr_row,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           start,
    input  logic                           ts_close,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OPCODE_W-1:0]            in_opcode,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_W-1:0]              out_dest,
    output logic [OPCODE_W-1:0]            out_opcode,
    output logic [DATA_W-1:0]              out_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int TS_W  = idx_w(NUM_TS);
    localparam int ROW_W = idx_w(IFMAP_SIZE);
    localparam int PPE_W = idx_w(NUM_PPE);
    localparam int CNT_W = idx_w(ROWS_PER_PPE + 1);

    localparam logic [PPE_W-1:0]  LAST_PPE = PPE_W'(NUM_PPE - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(ROWS_PER_PPE);
    localparam logic [TS_W-1:0]   LAST_TS  = TS_W'(NUM_TS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(PPE_BASE_ADDR);

    state_e state, state_d;

    logic [PPE_W-1:0]    k_q;
    logic [CNT_W-1:0]    cnt_q [NUM_PPE];
    logic [TS_W-1:0]     ts_q;
    logic [DATA_W-1:0]   rd_data;

    logic                out_load;
    logic                all_full;
    logic [ADDR_W-1:0]   req_off;
    logic [PPE_W-1:0]    req_k;
    logic                req_in_range;
    logic                req_legal;
    logic                store_wr;

    logic                issue;
    logic [ADDR_W-1:0]   issue_dest;
    logic [OPCODE_W-1:0] issue_op;
    logic                rd_en;
    logic [ROW_W-1:0]    rd_row;
    logic                k_step;
    logic                k_clear;
    logic                prime_set;
    logic                cnt_inc;
    logic                ts_adv;
    logic                ts_wrap;
    logic                set_err;
    logic                done_d;

    logic                unused_in_data;
    assign unused_in_data = ^in_data;

    // The output register may take a new packet when empty or handing its packet off now.
    assign out_load = !out_valid || out_ready;
    assign busy     = (state != ST_IDLE);
    assign out_data = (out_opcode == OP_INPUT) ? rd_data : '0;

    assign req_off      = in_opcode - BASE;
    assign req_in_range = (in_opcode >= BASE) && (req_off < ADDR_W'(NUM_PPE));
    assign req_k        = req_off[PPE_W-1:0];
    assign req_legal    = req_in_range && (cnt_q[req_k] < CNT_FULL);

    assign store_wr = wr_en && (state == ST_IDLE)
                      && ({1'b0, wr_row} < (ROW_W + 1)'(IFMAP_SIZE));

    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < NUM_PPE; i++) begin
            if (cnt_q[i] != CNT_FULL) begin
                all_full = 1'b0;
            end
        end
    end

    imem_row_store #(
        .NUM_TS (NUM_TS),
        .ROWS   (IFMAP_SIZE),
        .WIDTH  (DATA_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (store_wr),
        .wr_ts   (wr_ts),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_ts   (ts_q),
        .rd_row  (rd_row),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state;
        in_ready   = 1'b0;
        issue      = 1'b0;
        issue_dest = '0;
        issue_op   = OP_INPUT;
        rd_en      = 1'b0;
        rd_row     = '0;
        k_step     = 1'b0;
        k_clear    = 1'b0;
        prime_set  = 1'b0;
        cnt_inc    = 1'b0;
        ts_adv     = 1'b0;
        ts_wrap    = 1'b0;
        set_err    = 1'b0;
        done_d     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRIME;
                    k_clear = 1'b1;
                end
            end

            ST_PRIME: begin
                if (out_load) begin
                    issue      = 1'b1;
                    issue_dest = BASE + ADDR_W'(k_q);
                    rd_en      = 1'b1;
                    rd_row     = ROW_W'(k_q);
                    prime_set  = 1'b1;
                    if (k_q == LAST_PPE) begin
                        state_d = ST_SERVE;
                        k_clear = 1'b1;
                    end else begin
                        k_step = 1'b1;
                    end
                end
            end

            ST_SERVE: begin
                in_ready = out_load;
                if (in_valid && out_load) begin
                    if (req_legal) begin
                        issue      = 1'b1;
                        issue_dest = in_opcode;
                        rd_en      = 1'b1;
                        rd_row     = ROW_W'(req_k) + ROW_W'(cnt_q[req_k]);
                        cnt_inc    = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end
                // ts_close is a level, so an early close simply waits here for the last rows.
                if (all_full && !out_valid && ts_close) begin
                    state_d = ST_BCAST;
                    k_clear = 1'b1;
                end
            end

            ST_BCAST: begin
                if (out_load) begin
                    issue      = 1'b1;
                    issue_dest = BASE + ADDR_W'(k_q);
                    issue_op   = OP_TIMESTEP_DONE;
                    if (k_q == LAST_PPE) begin
                        k_clear = 1'b1;
                        if (ts_q != LAST_TS) begin
                            ts_adv  = 1'b1;
                            state_d = ST_PRIME;
                        end else begin
                            ts_wrap = 1'b1;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        k_step = 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_dest   <= '0;
            out_opcode <= '0;
            k_q        <= '0;
            ts_q       <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < NUM_PPE; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            done <= done_d;
            if (set_err) begin
                err <= 1'b1;
            end

            if (issue) begin
                out_valid  <= 1'b1;
                out_dest   <= issue_dest;
                out_opcode <= issue_op;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (k_clear) begin
                k_q <= '0;
            end else if (k_step) begin
                k_q <= k_q + PPE_W'(1);
            end

            if (ts_adv) begin
                ts_q <= ts_q + TS_W'(1);
            end else if (ts_wrap) begin
                ts_q <= '0;
            end

            for (int i = 0; i < NUM_PPE; i++) begin
                if (ts_adv) begin
                    cnt_q[i] <= '0;
                end else if (prime_set && (k_q == PPE_W'(i))) begin
                    cnt_q[i] <= CNT_W'(1);
                end else if (cnt_inc && (req_k == PPE_W'(i))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_row_server.sv
// Directed bench for imem_row_server: reset, priming, serve latency, back-pressure,
// illegal requests and a full two-timestep run against a packet scoreboard.
`timescale 1ns/1ps
module tb_imem_row_server;

    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  op;
        logic [24:0] data;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [0:0]  wr_ts;
    logic [4:0]  wr_row;
    logic [24:0] wr_data;
    logic        start;
    logic        ts_close;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [24:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_dest;
    logic [3:0]  out_opcode;
    logic [24:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    int   tests    = 0;
    int   failed   = 0;
    int   done_cnt = 0;
    int   cnt_m [5];
    int   ts_m;
    pkt_t rx_q [$];
    pkt_t exp_q [$];

    always #5 clk = ~clk;

    imem_row_server dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_ts      (wr_ts),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .start      (start),
        .ts_close   (ts_close),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dest   (out_dest),
        .out_opcode (out_opcode),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Inputs change 1 ns after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) rx_q.push_back({out_dest, out_opcode, out_data});
        if (rst_n && done) done_cnt++;
    end

    function automatic logic [24:0] row_val(input int t, input int r);
        logic [24:0] one;
        one = 25'h1;
        return (t == 0) ? (one << r) : (25'h1000000 | 25'(r));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < 25; r++) begin
                wr_en = 1'b1; wr_ts = 1'(t); wr_row = 5'(r); wr_data = row_val(t, r);
                tick(1);
            end
        end
        wr_en = 1'b1; wr_ts = 1'b0; wr_row = 5'd25; wr_data = 25'h1FFFFFF;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic send_req(input logic [3:0] addr);
        in_valid = 1'b1;
        in_opcode = addr;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick(1);
                in_valid = 1'b0;
                return;
            end
        end
        tests++; failed++;
        $display("FAIL req_timeout: addr %0d never accepted, want accept within 100 cycles", addr);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic req_legal(input int k);
        exp_q.push_back({4'(5 + k), 4'd1, row_val(ts_m, k + cnt_m[k])});
        cnt_m[k]++;
        send_req(4'(5 + k));
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 300 && rx_q.size() < n; i++) tick(1);
        tests++;
        if (rx_q.size() < n) begin
            failed++;
            $display("FAIL rx_timeout: got %0d packets want %0d", rx_q.size(), n);
        end
    endtask

    task automatic expect_prime(input int t);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back({4'(5 + k), 4'd1, row_val(t, k)});
            cnt_m[k] = 1;
        end
        ts_m = t;
    endtask

    task automatic expect_bcast();
        for (int k = 0; k < 5; k++) exp_q.push_back({4'(5 + k), 4'd15, 25'h0});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; wr_ts = 1'b0; wr_row = '0; wr_data = '0;
        start = 1'b0; ts_close = 1'b0; in_valid = 1'b0; in_opcode = '0;
        in_data = 25'h0AAAAAA; out_ready = 1'b1;
        tick(3);
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if ({out_dest, out_opcode, out_data} !== 33'h0) begin failed++; $display("FAIL reset_out_fields: got %h want 0", {out_dest, out_opcode, out_data}); end
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        tests++; if ({busy, done, err} !== 3'b000) begin failed++; $display("FAIL reset_status: got busy/done/err=%b want 000", {busy, done, err}); end
        rst_n = 1'b1;
        tick(3);
        tests++; if ({busy, out_valid} !== 2'b00) begin failed++; $display("FAIL idle_after_reset: got busy/out_valid=%b want 00", {busy, out_valid}); end
    endtask

    task automatic test_reset_mid_prime();
        out_ready = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        tests++; if ({busy, out_valid} !== 2'b11) begin failed++; $display("FAIL prime_stalled: got busy/out_valid=%b want 11", {busy, out_valid}); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({out_valid, busy, in_ready, done, err} !== 5'b0) begin failed++; $display("FAIL async_reset_ctrl: got %b want 00000", {out_valid, busy, in_ready, done, err}); end
        tests++; if ({out_dest, out_opcode, out_data} !== 33'h0) begin failed++; $display("FAIL async_reset_fields: got %h want 0", {out_dest, out_opcode, out_data}); end
        tick(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick(10);
        tests++; if (rx_q.size() != 0 || busy !== 1'b0) begin failed++; $display("FAIL post_reset_quiet: got %0d packets busy=%b want 0 packets busy=0", rx_q.size(), busy); end
        rx_q.delete();
    endtask

    task automatic test_prime();
        expect_prime(0);
        start = 1'b1; tick(1); start = 1'b0;
        wait_rx(5);
        tick(3);
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL prime_busy: got %b want 1", busy); end
        tests++; if (rx_q.size() != exp_q.size()) begin failed++; $display("FAIL prime_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin failed++; $display("FAIL prime_pkt%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_serve_latency();
        req_legal(2);
        tests++; if ({out_valid, out_dest, out_opcode, out_data} !== {1'b1, 4'd7, 4'd1, 25'h8}) begin failed++; $display("FAIL latency_first: got v=%b dest=%0d op=%0d data=%h want v=1 dest=7 op=1 data=0000008", out_valid, out_dest, out_opcode, out_data); end
        req_legal(2);
        tests++; if ({out_valid, out_dest, out_data} !== {1'b1, 4'd7, 25'h10}) begin failed++; $display("FAIL latency_second: got v=%b dest=%0d data=%h want v=1 dest=7 data=0000010", out_valid, out_dest, out_data); end
        wait_rx(2);
        tick(3);
        tests++; if (rx_q.size() != exp_q.size()) begin failed++; $display("FAIL serve_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin failed++; $display("FAIL serve_pkt%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_pressure();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        req_legal(0);
        in_valid = 1'b1; in_opcode = 4'd6;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dest !== 4'd5 || out_data !== 25'h2) bad++;
        end
        tests++; if (bad != 0) begin failed++; $display("FAIL bp_stall: got %0d unstable cycles want 0", bad); end
        tick(1);
        out_ready = 1'b1;
        req_legal(1);
        req_legal(3);
        wait_rx(3);
        tick(3);
        tests++; if (rx_q.size() != exp_q.size()) begin failed++; $display("FAIL bp_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin failed++; $display("FAIL bp_pkt%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_illegal();
        tests++; if (err !== 1'b0) begin failed++; $display("FAIL err_clear: got %b want 0", err); end
        send_req(4'd3);
        tests++; if ({err, out_valid} !== 2'b10) begin failed++; $display("FAIL err_out_of_range: got err/out_valid=%b want 10", {err, out_valid}); end
        wr_en = 1'b1; wr_ts = 1'b0; wr_row = 5'd3; wr_data = 25'h1ABCDEF;
        tick(1);
        wr_en = 1'b0;
        req_legal(0);
        req_legal(0);
        req_legal(0);
        send_req(4'd5);
        send_req(4'd10);
        tick(4);
        tests++; if (err !== 1'b1) begin failed++; $display("FAIL err_sticky: got %b want 1", err); end
        tests++; if (rx_q.size() != exp_q.size()) begin failed++; $display("FAIL illegal_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin failed++; $display("FAIL illegal_pkt%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_run();
        ts_close = 1'b1;
        tick(5);
        tests++; if (rx_q.size() != 0 || in_ready !== 1'b1) begin failed++; $display("FAIL close_held_off: got %0d packets in_ready=%b want 0 packets in_ready=1", rx_q.size(), in_ready); end
        for (int k = 0; k < 5; k++) while (cnt_m[k] < 5) req_legal(k);
        expect_bcast();
        expect_prime(1);
        wait_rx(exp_q.size());
        ts_close = 1'b0;
        tick(3);
        tests++; if (rx_q.size() != exp_q.size()) begin failed++; $display("FAIL ts0_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin failed++; $display("FAIL ts0_pkt%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();

        for (int k = 0; k < 5; k++) while (cnt_m[k] < 5) req_legal(k);
        tests++; if (done_cnt != 0) begin failed++; $display("FAIL done_early: got %0d pulses want 0", done_cnt); end
        ts_close = 1'b1;
        expect_bcast();
        wait_rx(exp_q.size());
        ts_close = 1'b0;
        tick(4);
        tests++; if (rx_q.size() != exp_q.size()) begin failed++; $display("FAIL ts1_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== exp_q[i]) begin failed++; $display("FAIL ts1_pkt%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        rx_q.delete(); exp_q.delete();
        tests++; if (done_cnt != 1) begin failed++; $display("FAIL done_pulse: got %0d pulses want 1", done_cnt); end
        tests++; if ({busy, err} !== 2'b01) begin failed++; $display("FAIL final_status: got busy/err=%b want 01", {busy, err}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200 us");
        $fatal(1);
    end

    initial begin
        test_reset();
        load_mem();
        test_reset_mid_prime();
        test_prime();
        test_serve_latency();
        test_back_pressure();
        test_illegal();
        test_full_run();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
